led_mode_scheduler: RTL

//  Shares the board LED bank between NUM_SRC pattern generators (cycle, blinker, ...).

---
 rtl/led_mode_scheduler.sv | 133 +++++++++++++
 1 files changed

// File: rtl/led_mode_scheduler.sv
// led_mode_scheduler: shares an LED bank between NUM_SRC pattern sources, round-robin on button/dwell, with blank gaps.
// Optional feature: define LED_DIM_EN to add dim_level[3:0] and 16-step PWM dimming of the LED drive.
module led_mode_scheduler #(
    parameter int NUM_SRC     = 3,
    parameter int LED_WIDTH   = 4,
    parameter int TICK_DIV    = 25_000_000,
    parameter int DEB_CYCLES  = 1_000_000,
    parameter int DWELL_TICKS = 16,
    parameter int BLANK_TICKS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           btn,
    input  logic                           auto_mode,
    input  logic [NUM_SRC*LED_WIDTH-1:0]   src_led,
`ifdef LED_DIM_EN
    input  logic [3:0]                     dim_level,
`endif
    output logic                           tick,
    output logic [NUM_SRC-1:0]             src_enable,
    output logic [$clog2(NUM_SRC)-1:0]     mode,
    output logic [LED_WIDTH-1:0]           led
);
    localparam int DIV_W   = $clog2(TICK_DIV);
    localparam int DEB_W   = $clog2(DEB_CYCLES + 1);
    localparam int DWELL_W = $clog2(DWELL_TICKS + 1);
    localparam int BLANK_W = $clog2(BLANK_TICKS + 1);
    localparam int MW      = $clog2(NUM_SRC);

    typedef enum logic {BLANK, RUN} state_t;

    state_t               state_q, state_d;
    logic [DIV_W-1:0]     div_cnt_q, div_cnt_d;
    logic [1:0]           sync_q, sync_d;
    logic [DEB_W-1:0]     deb_cnt_q, deb_cnt_d;
    logic                 deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [BLANK_W-1:0]   blank_cnt_q, blank_cnt_d;
    logic [DWELL_W-1:0]   dwell_cnt_q, dwell_cnt_d;
    logic [MW-1:0]        mode_q, mode_d;
    logic [LED_WIDTH-1:0] led_q, led_d, pattern;
    logic                 btn_evt, deb_differ, dwell_exp, gate;
`ifdef LED_DIM_EN
    logic [3:0]           pwm_cnt_q, pwm_cnt_d;
`endif

    assign tick = (div_cnt_q == DIV_W'(TICK_DIV - 1));
    assign mode = mode_q;
    assign led  = led_q;

    // Prescaler, button synchroniser and debouncer with rising-edge event
    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        sync_d     = {sync_q[0], btn};
        deb_differ = (sync_q[1] != deb_q);
        deb_cnt_d  = (deb_differ && deb_cnt_q != DEB_W'(DEB_CYCLES - 1)) ? deb_cnt_q + 1'b1 : '0;
        deb_d      = (deb_differ && deb_cnt_q == DEB_W'(DEB_CYCLES - 1)) ? sync_q[1] : deb_q;
        deb_prev_d = deb_q;
        btn_evt    = deb_q & ~deb_prev_q;
    end

    // BLANK/RUN sequencing, source selection and next LED value
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        blank_cnt_d = blank_cnt_q;
        dwell_cnt_d = dwell_cnt_q;
        src_enable  = '0;
        led_d       = '0;
        dwell_exp   = 1'b0;
`ifdef LED_DIM_EN
        pwm_cnt_d   = pwm_cnt_q + 1'b1;
        gate        = (pwm_cnt_q < dim_level);
`else
        gate        = 1'b1;
`endif
        pattern     = src_led[mode_q*LED_WIDTH +: LED_WIDTH] & {LED_WIDTH{gate}};
        if (state_q == BLANK) begin
            if (tick) begin
                if (blank_cnt_q == BLANK_W'(BLANK_TICKS - 1)) begin
                    state_d     = RUN;
                    blank_cnt_d = '0;
                    dwell_cnt_d = '0;
                end else begin
                    blank_cnt_d = blank_cnt_q + 1'b1;
                end
            end
        end else begin
            src_enable = NUM_SRC'(1) << mode_q;
            dwell_exp  = auto_mode && tick && (dwell_cnt_q == DWELL_W'(DWELL_TICKS - 1));
            if (btn_evt || dwell_exp) begin
                mode_d      = (mode_q == MW'(NUM_SRC - 1)) ? '0 : mode_q + 1'b1;
                state_d     = BLANK;
                blank_cnt_d = '0;
            end else begin
                led_d = pattern;
                if (auto_mode && tick) dwell_cnt_d = dwell_cnt_q + 1'b1;
            end
        end
    end

    // State registers; asynchronous reset returns everything to dark/idle at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BLANK;
            div_cnt_q   <= '0;
            sync_q      <= '0;
            deb_cnt_q   <= '0;
            deb_q       <= 1'b0;
            deb_prev_q  <= 1'b0;
            blank_cnt_q <= '0;
            dwell_cnt_q <= '0;
            mode_q      <= '0;
            led_q       <= '0;
`ifdef LED_DIM_EN
            pwm_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            sync_q      <= sync_d;
            deb_cnt_q   <= deb_cnt_d;
            deb_q       <= deb_d;
            deb_prev_q  <= deb_prev_d;
            blank_cnt_q <= blank_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            mode_q      <= mode_d;
            led_q       <= led_d;
`ifdef LED_DIM_EN
            pwm_cnt_q   <= pwm_cnt_d;
`endif
        end
    end
endmodule
